instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of 8-bit program memory words.
REQ-002 Parameter ADDR_W, default 5, SHALL set the program counter and load-address width, with DEPTH = 2**ADDR_W.
REQ-003 Parameter HALT_OP, default 8'hFF, SHALL be the opcode that ends a program without issuing it.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum WAIT cycles allowed before alu_done.
REQ-005 The block SHALL use one clock, clk (input, 1), with all state on its rising edge.
REQ-006 reset (input, 1) SHALL be the asynchronous, active-high reset.
REQ-007 init (input, 1) SHALL start program execution when sampled high in IDLE, DONE or ERROR.
REQ-008 load_en (input, 1) SHALL write load_data into program memory at load_addr.
REQ-009 load_addr (input, ADDR_W) SHALL be the program memory write address.
REQ-010 load_data (input, 8) SHALL be the program memory write data.
REQ-011 alu_done (input, 1) SHALL be the downstream ALU's completion of the current instruction.
REQ-012 instrucciones (output, 8) SHALL be the instruction word presented to the ALU.
REQ-013 active (output, 1) SHALL be a one-cycle strobe marking instrucciones valid for the ALU.
REQ-014 pc (output, ADDR_W) SHALL be the current program counter.
REQ-015 busy (output, 1) SHALL be high in FETCH, ISSUE and WAIT.
REQ-016 done (output, 1) SHALL be high in DONE.
REQ-017 error (output, 1) SHALL be high in ERROR.

Function
REQ-018 The FSM SHALL have five states: IDLE, FETCH, ISSUE, WAIT, DONE, plus ERROR; all outputs SHALL be registered.
REQ-019 Program memory SHALL be written only when load_en is high in IDLE, DONE or ERROR; writes in any other state SHALL be ignored.
REQ-020 init high in IDLE, DONE or ERROR SHALL clear pc, done and error and go to FETCH; init in any other state SHALL be ignored.
REQ-021 If load_en and init are high together, the write SHALL complete and FETCH SHALL read the updated contents.
REQ-022 FETCH SHALL register mem[pc] in one cycle and go to ISSUE.
REQ-023 ISSUE with word == HALT_OP SHALL go to DONE with no active pulse.
REQ-024 ISSUE with any other word SHALL drive instrucciones = word and active = 1 for exactly one cycle, then go to WAIT.
REQ-025 The first active SHALL appear 2 cycles after the edge that samples init; instrucciones SHALL hold its value until the next issue.
REQ-026 alu_done SHALL be sampled only in WAIT, starting the cycle after active; alu_done in any other state SHALL be ignored.
REQ-027 alu_done in WAIT with pc < DEPTH-1 SHALL increment pc and go to FETCH, giving 3 cycles from alu_done to the next active.
REQ-028 alu_done in WAIT with pc == DEPTH-1 SHALL go to DONE with pc held at DEPTH-1; pc SHALL never wrap.
REQ-029 The WAIT counter SHALL clear on entering WAIT and increment each WAIT cycle without alu_done.
REQ-030 The WAIT counter reaching TIMEOUT SHALL force ERROR with active = 0 and pc frozen.
REQ-031 If alu_done arrives in the same cycle the counter reaches TIMEOUT, alu_done SHALL take priority.
REQ-032 DONE and ERROR SHALL be held until init or reset.

Reset
REQ-033 reset SHALL force, asynchronously and in any state, IDLE, pc = 0, instrucciones = 8'h00, active = 0, busy = 0, done = 0, error = 0 and WAIT counter = 0.
REQ-034 reset SHALL NOT clear program memory contents.
REQ-035 After reset deasserts, init SHALL replay the program from address 0.

Verification
REQ-036 Load 0x12, 0x34, 0xFF at addresses 0-2, pulse init, return alu_done 3 cycles after each active -> active pulses carrying 0x12 then 0x34, then done = 1 with pc = 2 and no third pulse.
REQ-037 Load 32 non-halt words, give an immediate alu_done each time -> exactly 32 active pulses in address order, then done = 1 with pc = 31 and no wrap.
REQ-038 Issue one instruction and withhold alu_done -> error = 1 and busy = 0 exactly TIMEOUT cycles into WAIT; a following init restarts from pc = 0 with error = 0.
REQ-039 Assert reset mid-WAIT at pc = 5 -> all outputs 0 in the same cycle; memory is retained; the next init reissues mem[0].
REQ-040 Apply load_en, init and a stray alu_done while busy -> memory unchanged, sequence unaffected, pc does not advance on the stray alu_done.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks a small program memory, issuing one opcode at a
// time to a downstream ALU and waiting for its completion handshake. A halt
// opcode, the last memory word or an ALU timeout ends the program.
module instr_sequencer #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter logic [7:0]  HALT_OP = 8'hFF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              alu_done,
    output logic [7:0]        instrucciones,
    output logic              active,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            state_q;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        word_q;
    logic [7:0]        instr_q;
    logic              active_q;
    logic [ADDR_W-1:0] pc_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_ok;

    // Loads and program starts are only honoured while no program is running.
    assign cmd_ok = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);

    // Program memory write port; deliberately not reset so a program survives reset.
    always_ff @(posedge clk) begin
        if (load_en && cmd_ok) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Fetch register: captures the word at pc while in FETCH.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH) begin
            word_q <= mem_q[pc_q];
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= 8'h00;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (init) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (word_q == HALT_OP) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_WAIT;
                        instr_q  <= word_q;
                        active_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                S_WAIT: begin
                    // A completion in the final allowed cycle still wins over the timeout.
                    if (alu_done) begin
                        if (pc_q == LAST_PC) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            pc_q    <= pc_q + ADDR_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == TO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instrucciones = instr_q;
    assign active        = active_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a cycle table for a short program,
// hand-written corner sequences, and randomized programs compared against a
// program-level reference model.
module tb_instr_sequencer;

    localparam int         DEPTH = 32;
    localparam int         AW    = 5;
    localparam int         TO    = 255;
    localparam logic [7:0] HALT  = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          alu_done;
    logic [7:0]    instrucciones;
    logic          active;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          error;

    instr_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .HALT_OP(HALT),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .alu_done     (alu_done),
        .instrucciones(instrucciones),
        .active       (active),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl_mem [DEPTH];
    int         dly_tab [DEPTH];
    logic [7:0] exp_instr;

    int         q_cyc[$];
    logic [7:0] q_word[$];
    int         q_pc[$];
    int         end_kind;
    int         end_pc;
    int         end_cyc;

    typedef struct packed {
        logic          i_init;
        logic          i_ld;
        logic [AW-1:0] i_addr;
        logic [7:0]    i_data;
        logic          i_done;
        logic          e_act;
        logic [7:0]    e_instr;
        logic [AW-1:0] e_pc;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic vec_t mk(logic ii, logic ld, int a, int d, logic ad,
                                logic act, int ins, int p, logic b, logic dn, logic er);
        vec_t v;
        v.i_init  = ii;
        v.i_ld    = ld;
        v.i_addr  = AW'(a);
        v.i_data  = 8'(d);
        v.i_done  = ad;
        v.e_act   = act;
        v.e_instr = 8'(ins);
        v.e_pc    = AW'(p);
        v.e_busy  = b;
        v.e_done  = dn;
        v.e_err   = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic a, input logic [7:0] ins,
                            input int p, input logic b, input logic d, input logic e);
        chk({nm, ".active"}, 32'(active), 32'(a));
        chk({nm, ".instr"},  32'(instrucciones), 32'(ins));
        chk({nm, ".pc"},     32'(pc), 32'(p));
        chk({nm, ".busy"},   32'(busy), 32'(b));
        chk({nm, ".done"},   32'(done), 32'(d));
        chk({nm, ".error"},  32'(error), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        init     = 1'b0;
        load_en  = 1'b0;
        alu_done = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        chk_outs(nm, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        reset     = 1'b0;
        exp_instr = 8'h00;
    endtask

    task automatic load_word(input int a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        tick();
        load_en     = 1'b0;
        mdl_mem[a]  = d;
    endtask

    // Program-level model: walk addresses, issue each non-halt word, and apply the
    // ALU response delay (cycles after the active strobe) chosen for that issue.
    task automatic build_model();
        int t;
        t = 3;
        q_cyc.delete();
        q_word.delete();
        q_pc.delete();
        end_kind = 0;
        end_pc   = 0;
        end_cyc  = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (mdl_mem[a] == HALT) begin
                end_kind = 1; end_pc = a; end_cyc = t;
                break;
            end
            q_cyc.push_back(t);
            q_word.push_back(mdl_mem[a]);
            q_pc.push_back(a);
            if (dly_tab[a] >= TO) begin
                end_kind = 2; end_pc = a; end_cyc = t + TO;
                break;
            end
            if (a == DEPTH - 1) begin
                end_kind = 1; end_pc = a; end_cyc = t + dly_tab[a] + 1;
                break;
            end
            t = t + dly_tab[a] + 3;
        end
    endtask

    task automatic run_prog(input string tag, input bit strays);
        int k, idx, n_act, deadline;
        bit pending, exp_act;
        build_model();
        init = 1'b1; load_en = 1'b0; alu_done = 1'b0;
        tick();
        init = 1'b0;
        k = 1; idx = 0; n_act = 0; pending = 1'b0; deadline = 0;
        while (k <= end_cyc) begin
            exp_act = (idx < q_cyc.size()) && (q_cyc[idx] == k);
            chk({tag, ".active"}, 32'(active), 32'(exp_act));
            if (exp_act) begin
                chk({tag, ".instr"}, 32'(instrucciones), 32'(q_word[idx]));
                chk({tag, ".pc"}, 32'(pc), 32'(q_pc[idx]));
                exp_instr = q_word[idx];
                idx++;
            end else begin
                chk({tag, ".instr_hold"}, 32'(instrucciones), 32'(exp_instr));
            end
            chk({tag, ".busy"},  32'(busy),  32'(k < end_cyc));
            chk({tag, ".done"},  32'(done),  32'(k == end_cyc && end_kind == 1));
            chk({tag, ".error"}, 32'(error), 32'(k == end_cyc && end_kind == 2));
            if (k == end_cyc) begin
                chk({tag, ".end_pc"}, 32'(pc), 32'(end_pc));
                break;
            end
            if (active && n_act < DEPTH) begin
                pending  = 1'b1;
                deadline = k + dly_tab[n_act];
                n_act++;
            end
            alu_done = 1'b0;
            if (pending && k == deadline) begin
                alu_done = 1'b1;
                pending  = 1'b0;
            end else if (!pending && strays) begin
                alu_done = ($urandom_range(0, 3) == 0);
            end
            if (strays) begin
                init      = ($urandom_range(0, 7) == 0);
                load_en   = ($urandom_range(0, 2) == 0);
                load_addr = AW'($urandom_range(0, DEPTH - 1));
                load_data = 8'($urandom_range(0, 255));
            end
            tick();
            k++;
        end
        init = 1'b0; load_en = 1'b0; alu_done = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        bit found;
        int r;
        reset = 1'b1; init = 1'b0; load_en = 1'b0; alu_done = 1'b0;
        load_addr = '0; load_data = 8'h00; exp_instr = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = 8'h00;
            dly_tab[i] = 0;
        end

        do_reset("reset");

        // Three-word program with halt; ALU answers 3 cycles after each strobe.
        tbl[0]  = mk(0, 1, 0, 8'h12, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 8'h34, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 2, 8'hFF, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 8'h00, 0,  1, 8'h12, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h12, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h12, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h12, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 8'h00, 1,  0, 8'h12, 1, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 8'h00, 0,  0, 8'h12, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 8'h00, 0,  1, 8'h34, 1, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 8'h00, 0,  0, 8'h34, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 0,  0, 8'h34, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 8'h00, 0,  0, 8'h34, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 8'h00, 1,  0, 8'h34, 2, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 8'h00, 0,  0, 8'h34, 2, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 8'h00, 0,  0, 8'h34, 2, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 8'h00, 1,  0, 8'h34, 2, 0, 1, 0);
        for (int i = 0; i < NV; i++) begin
            init      = tbl[i].i_init;
            load_en   = tbl[i].i_ld;
            load_addr = tbl[i].i_addr;
            load_data = tbl[i].i_data;
            alu_done  = tbl[i].i_done;
            tick();
            chk_outs($sformatf("tbl[%0d]", i), tbl[i].e_act, tbl[i].e_instr,
                     int'(tbl[i].e_pc), tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
        end
        init = 1'b0; load_en = 1'b0; alu_done = 1'b0;
        mdl_mem[0] = 8'h12; mdl_mem[1] = 8'h34; mdl_mem[2] = 8'hFF;
        exp_instr = 8'h34;

        // Full memory, no halt, immediate completion: 32 issues then done at pc 31.
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, 8'(8'h40 + i));
            dly_tab[i] = 0;
        end
        run_prog("full32", 1'b0);

        // Same program with stray load/init/alu_done activity while busy.
        for (int i = 0; i < DEPTH; i++) dly_tab[i] = int'($urandom_range(0, 3));
        run_prog("stray", 1'b1);

        // Timeout on the second issue, then restart from pc 0.
        load_word(0, 8'h21);
        load_word(1, 8'h22);
        init = 1'b1; tick(); init = 1'b0;
        chk("to.start_busy", 32'(busy), 32'd1);
        chk("to.start_pc", 32'(pc), 32'd0);
        tick(); tick();
        chk_outs("to.issue0", 1'b1, 8'h21, 0, 1'b1, 1'b0, 1'b0);
        alu_done = 1'b1; tick(); alu_done = 1'b0;
        chk("to.pc_adv", 32'(pc), 32'd1);
        tick(); tick();
        chk_outs("to.issue1", 1'b1, 8'h22, 1, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= TO; j++) begin
            tick();
            if (j < TO) chk("to.no_err_yet", 32'(error), 32'd0);
        end
        chk_outs("to.error", 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b1);
        alu_done = 1'b1; tick(); alu_done = 1'b0;
        chk("to.err_held", 32'(error), 32'd1);
        chk("to.pc_frozen", 32'(pc), 32'd1);
        init = 1'b1; tick(); init = 1'b0;
        chk_outs("to.restart", 1'b0, 8'h22, 0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_outs("to.reissue", 1'b1, 8'h21, 0, 1'b1, 1'b0, 1'b0);
        do_reset("reset2");

        // Load and init in the same cycle: fetch sees the new word.
        load_en = 1'b1; load_addr = '0; load_data = 8'h5A; init = 1'b1;
        tick();
        load_en = 1'b0; init = 1'b0; mdl_mem[0] = 8'h5A;
        tick(); tick();
        chk_outs("ldinit", 1'b1, 8'h5A, 0, 1'b1, 1'b0, 1'b0);
        do_reset("reset3");

        // Asynchronous reset in WAIT at pc 5, then replay from address 0.
        for (int i = 0; i < 6; i++) load_word(i, 8'(8'h30 + i));
        load_word(6, HALT);
        init = 1'b1; tick(); init = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            alu_done = 1'b0;
            if (active && pc == AW'(5)) found = 1'b1;
            else begin
                alu_done = active;
                tick();
            end
        end
        alu_done = 1'b0;
        chk("arst.reached_pc5", 32'(found), 32'd1);
        tick();
        chk("arst.pre_pc", 32'(pc), 32'd5);
        chk("arst.pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("arst.async", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        exp_instr = 8'h00;
        init = 1'b1; tick(); init = 1'b0;
        tick(); tick();
        chk_outs("arst.replay0", 1'b1, 8'h30, 0, 1'b1, 1'b0, 1'b0);
        alu_done = 1'b1; tick(); alu_done = 1'b0;
        tick(); tick();
        chk_outs("arst.replay1", 1'b1, 8'h31, 1, 1'b1, 1'b0, 1'b0);
        do_reset("reset4");

        // Randomized programs with occasional halts, tie-cycle completions and timeouts.
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 29) == 0) load_word(i, HALT);
                else load_word(i, 8'($urandom_range(0, 254)));
                r = int'($urandom_range(0, 99));
                if (r < 80)      dly_tab[i] = int'($urandom_range(0, 3));
                else if (r < 97) dly_tab[i] = int'($urandom_range(4, 12));
                else if (r < 99) dly_tab[i] = TO - 1;
                else             dly_tab[i] = TO;
            end
            run_prog($sformatf("rnd%0d", p), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
